hex_scroll_engine: RTL and testbench
====================================

Name: hex_scroll_engine

Overview:
- Upstream character-stream generator for the seven-segment display path.
- Holds a writable message buffer of glyph codes and produces one glyph code per HEX digit (six digits).
- Scrolls the message across the digits one position per tick pulse from the existing tick_1hz divider.
- The per-digit codes feed seg7_letter-style decoders directly.

Parameters:
- NUM_DIGITS, 6, number of display digits driven.
- MSG_DEPTH, 16, message buffer entries (power of two).
- CODE_W, 5, glyph code width.
- BLANK_CODE, 5'h1F, glyph code meaning an all-segments-off digit.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- i_tick  input  1  one-cycle scroll strobe.
- i_wr_en  input  1  buffer write strobe.
- i_wr_addr  input  log2(MSG_DEPTH)  buffer write address.
- i_wr_code  input  CODE_W  glyph code to write.
- i_len  input  log2(MSG_DEPTH)+1  message length, sampled on start.
- i_start  input  1  begin scrolling.
- i_stop  input  1  abort scrolling and return to idle.
- i_pause  input  1  level; freezes scrolling while high.
- i_dir  input  1  0 = text moves right-to-left; 1 = left-to-right.
- o_codes  output  NUM_DIGITS*CODE_W  digit k (0 = leftmost) at bits [CODE_W*(NUM_DIGITS-1-k) +: CODE_W].
- o_running  output  1  high in RUN or PAUSE.
- o_wrap  output  1  one-cycle pulse when the scroll position wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, position p = 0, latched length L = 0.
  - Every o_codes digit = BLANK_CODE; o_running = 0; o_wrap = 0.
  - Buffer contents are NOT cleared by rst.
- Virtual stream: NUM_DIGITS blanks followed by buffer[0..L-1]. Period P = L + NUM_DIGITS.
  - Digit k shows stream[(p+k) mod P].
  - Because p < P and k < NUM_DIGITS <= P, a single conditional subtract of P suffices. No divider.
- Writes: accepted only in IDLE, and take effect on the next edge. Writes in RUN or PAUSE are dropped.
- State machine:
  - IDLE:
    - i_start with 1 <= i_len <= MSG_DEPTH: latch L = i_len, p = 0, go to RUN.
    - Out-of-range i_len: start is ignored and the block stays in IDLE.
  - RUN:
    - i_stop: go to IDLE.
    - Else i_pause: go to PAUSE.
    - Else i_tick: step p.
  - PAUSE:
    - i_stop: go to IDLE.
    - Else !i_pause: go to RUN.
    - Ticks are ignored in PAUSE.
- Step rules:
  - i_dir = 0: p = (p == P-1) ? 0 : p+1.
  - i_dir = 1: p = (p == 0) ? P-1 : p-1.
  - o_wrap pulses for exactly one cycle on the edge where p takes the wrapped value (P-1 to 0, or 0 to P-1).
- Latency: o_codes is registered and updated on the same edge that p changes, so it reflects the new p one cycle after the tick is sampled.
- On entering IDLE (by stop or reset), o_codes goes to all BLANK_CODE on that edge.
- Simultaneous events:
  - i_start and i_stop together: stop wins.
  - i_tick on the start cycle: ignored, p = 0.
  - i_tick with i_pause in RUN: pause wins and no step occurs.
  - i_wr_en with i_start in IDLE: the write completes, and the start uses the pre-write buffer for at most one cycle. Callers must not rely on same-cycle write and start.
- i_dir may change at any time and applies to the next step. It has no effect on p by itself.
- i_len is sampled only at start; changes during RUN are ignored.
- rst during RUN or PAUSE: behaves exactly as the reset values above on the next edge.

Test Plan:
- Reset then idle: assert rst 2 cycles, then hold all inputs low for 10 cycles -> o_codes = all 1F, o_running = 0, o_wrap = 0.
- HELLO forward scroll:
  - Setup: write codes 0,1,2,2,3 to addresses 0-4, i_len = 5, pulse i_start, then 5 ticks.
  - Start cycle: o_codes all 1F.
  - After tick 1: digit 5 = 0.
  - After tick 5: digits = 1F,0,1,2,2,3.
  - After tick 11: all 1F and o_wrap pulses for exactly one cycle.
- Reverse direction: same HELLO setup, i_dir = 1, one tick -> p = 10, digits = 3,1F,1F,1F,1F,1F, o_wrap pulses once.
- Pause and stop:
  - In RUN at p = 3, hold i_pause and give 4 ticks -> o_codes unchanged.
  - Release i_pause and give 1 tick -> p = 4.
  - Pulse i_stop together with i_start -> IDLE, all 1F.
- Illegal length: i_len = 0 with i_start, then i_len = 17 with i_start -> o_running stays 0.
- Write lockout and mid-run reset:
  - Write address 0 = 7 during RUN -> after stop and restart, digit 5 after tick 1 still shows 0.
  - Assert rst mid-RUN -> the next edge gives all 1F, o_running = 0, and the buffer is preserved.

Source files
------------

// File: rtl/hex_scroll_engine.sv
// Scrolls a writable glyph message across NUM_DIGITS seven-segment digits, one step per tick.
// Latency: o_codes/o_wrap are registered and reflect a step or state change one cycle after the input is sampled.
// Backpressure: none; ticks arriving in IDLE or PAUSE are dropped, and buffer writes arriving outside IDLE are dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_tick            one-cycle scroll strobe
//   i_wr_en/addr/code message buffer write port (IDLE only)
//   i_len             message length, sampled on start (1..MSG_DEPTH)
//   i_start/i_stop    begin / abort scrolling (stop wins)
//   i_pause           level, freezes scrolling
//   i_dir             0 = text moves right-to-left, 1 = left-to-right
//   o_codes           digit k (0 = leftmost) at [CODE_W*(NUM_DIGITS-1-k) +: CODE_W]
//   o_running         high in RUN or PAUSE
//   o_wrap            one-cycle pulse when the scroll position wraps
module hex_scroll_engine #(
    parameter int                 NUM_DIGITS = 6,
    parameter int                 MSG_DEPTH  = 16,
    parameter int                 CODE_W     = 5,
    parameter logic [CODE_W-1:0]  BLANK_CODE = 5'h1F
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_tick,
    input  logic                           i_wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   i_wr_addr,
    input  logic [CODE_W-1:0]              i_wr_code,
    input  logic [$clog2(MSG_DEPTH):0]     i_len,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_pause,
    input  logic                           i_dir,
    output logic [NUM_DIGITS*CODE_W-1:0]   o_codes,
    output logic                           o_running,
    output logic                           o_wrap
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    // Position and period never exceed MSG_DEPTH + NUM_DIGITS.
    localparam int PW = $clog2(MSG_DEPTH + NUM_DIGITS + 1);
    // Index width holds p + k before the conditional wrap.
    localparam int IW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                p_q, p_d;
    logic [LW-1:0]                len_q, len_d;
    logic                         wrap_d;
    logic [PW-1:0]                per_cur;
    logic [PW-1:0]                per_nxt;
    logic                         len_ok;
    logic [NUM_DIGITS*CODE_W-1:0] codes_d;

    logic [CODE_W-1:0] msg_mem [MSG_DEPTH];

    assign per_cur = PW'(len_q) + PW'(NUM_DIGITS);
    assign per_nxt = PW'(len_d) + PW'(NUM_DIGITS);
    assign len_ok  = (i_len != '0) && (i_len <= LW'(MSG_DEPTH));

    // Message buffer: not reset, only writable while idle.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && i_wr_en) begin
            msg_mem[i_wr_addr] <= i_wr_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            len_q   <= '0;
            o_codes <= {NUM_DIGITS{BLANK_CODE}};
            o_wrap  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            len_q   <= len_d;
            o_codes <= codes_d;
            o_wrap  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_stop && i_start && len_ok) begin
                    state_d = RUN;
                    len_d   = i_len;
                    p_d     = '0;
                end
            end
            RUN: begin
                if (i_stop) begin
                    state_d = IDLE;
                    p_d     = '0;
                end else if (i_pause) begin
                    state_d = PAUSE;
                end else if (i_tick) begin
                    if (!i_dir) begin
                        if (p_q == per_cur - PW'(1)) begin
                            p_d    = '0;
                            wrap_d = 1'b1;
                        end else begin
                            p_d = p_q + PW'(1);
                        end
                    end else begin
                        if (p_q == '0) begin
                            p_d    = per_cur - PW'(1);
                            wrap_d = 1'b1;
                        end else begin
                            p_d = p_q - PW'(1);
                        end
                    end
                end
            end
            PAUSE: begin
                if (i_stop) begin
                    state_d = IDLE;
                    p_d     = '0;
                end else if (!i_pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                p_d     = '0;
            end
        endcase
    end

    // Output codes are computed from the next position so they update on the
    // same edge as p. The first NUM_DIGITS stream slots are leading blanks;
    // since p < P and k < NUM_DIGITS <= P, one conditional subtract wraps.
    always_comb begin : codes_calc
        logic [IW-1:0] idx;
        codes_d = {NUM_DIGITS{BLANK_CODE}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            idx = IW'(p_d) + IW'(k);
            if (idx >= IW'(per_nxt)) begin
                idx = idx - IW'(per_nxt);
            end
            if (state_d != IDLE && idx >= IW'(NUM_DIGITS)) begin
                codes_d[CODE_W*(NUM_DIGITS-1-k) +: CODE_W] = msg_mem[AW'(idx - IW'(NUM_DIGITS))];
            end
        end
    end

    assign o_running = (state_q != IDLE);

endmodule

// File: tb/tb_hex_scroll_engine.sv
module tb_hex_scroll_engine;

    localparam int ND = 6;
    localparam int CW = 5;
    localparam logic [CW-1:0] BL = 5'h1F;
    localparam logic [ND*CW-1:0] ALL_BLANK = {ND{BL}};

    logic          clk = 1'b0;
    logic          rst;
    logic          i_tick, i_wr_en, i_start, i_stop, i_pause, i_dir;
    logic [3:0]    i_wr_addr;
    logic [CW-1:0] i_wr_code;
    logic [4:0]    i_len;
    logic [ND*CW-1:0] o_codes;
    logic          o_running, o_wrap;

    always #5 clk = ~clk;

    hex_scroll_engine dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_wr_en(i_wr_en),
        .i_wr_addr(i_wr_addr), .i_wr_code(i_wr_code), .i_len(i_len),
        .i_start(i_start), .i_stop(i_stop), .i_pause(i_pause), .i_dir(i_dir),
        .o_codes(o_codes), .o_running(o_running), .o_wrap(o_wrap)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 run, 2 pause; stream defined by modulo arithmetic.
    int          m_mode = 0;
    int          m_p = 0;
    int          m_len = 0;
    bit          m_wrap = 1'b0;
    bit          m_valid = 1'b0;
    logic [CW-1:0] m_buf [16];

    always @(posedge clk) begin
        int per;
        per = m_len + ND;
        if (rst) begin
            m_mode = 0; m_p = 0; m_len = 0; m_wrap = 1'b0; m_valid = 1'b1;
        end else begin
            m_wrap = 1'b0;
            case (m_mode)
                0: begin
                    if (i_wr_en) m_buf[i_wr_addr] = i_wr_code;
                    if (i_start && !i_stop && i_len >= 1 && i_len <= 16) begin
                        m_mode = 1; m_len = i_len; m_p = 0;
                    end
                end
                1: begin
                    if (i_stop) m_mode = 0;
                    else if (i_pause) m_mode = 2;
                    else if (i_tick) begin
                        if (!i_dir) begin
                            m_p = (m_p + 1) % per;
                            m_wrap = (m_p == 0);
                        end else begin
                            m_p = (m_p + per - 1) % per;
                            m_wrap = (m_p == per - 1);
                        end
                    end
                end
                default: begin
                    if (i_stop) m_mode = 0;
                    else if (!i_pause) m_mode = 1;
                end
            endcase
        end
    end

    function automatic logic [ND*CW-1:0] model_codes();
        logic [ND*CW-1:0] r;
        int s;
        r = ALL_BLANK;
        if (m_mode != 0) begin
            for (int k = 0; k < ND; k++) begin
                s = (m_p + k) % (m_len + ND);
                if (s >= ND) r[CW*(ND-1-k) +: CW] = m_buf[s-ND];
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_codes", 64'(o_codes), 64'(model_codes()));
            chk("model_running", 64'(o_running), 64'(m_mode != 0));
            chk("model_wrap", 64'(o_wrap), 64'(m_wrap));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        i_tick = 1'b1; cyc(); i_tick = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [CW-1:0] c);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_code = c; cyc(); i_wr_en = 1'b0;
    endtask

    task automatic start(input logic [4:0] len);
        i_len = len; i_start = 1'b1; cyc(); i_start = 1'b0;
    endtask

    task automatic stop();
        i_stop = 1'b1; cyc(); i_stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_tick = 0; i_wr_en = 0; i_start = 0; i_stop = 0;
        i_pause = 0; i_dir = 0; i_wr_addr = '0; i_wr_code = '0; i_len = '0;
        cyc(); cyc();
        rst = 1'b0;
        repeat (10) cyc();
        chk("reset_codes", 64'(o_codes), 64'(ALL_BLANK));
        chk("reset_running", 64'(o_running), 64'd0);
        chk("reset_wrap", 64'(o_wrap), 64'd0);

        // HELLO forward scroll
        wr(0, 5'd0); wr(1, 5'd1); wr(2, 5'd2); wr(3, 5'd2); wr(4, 5'd3);
        start(5);
        chk("start_codes", 64'(o_codes), 64'(ALL_BLANK));
        chk("start_running", 64'(o_running), 64'd1);
        tick();
        chk("tick1", 64'(o_codes), 64'({BL, BL, BL, BL, BL, 5'd0}));
        repeat (4) tick();
        chk("tick5", 64'(o_codes), 64'({BL, 5'd0, 5'd1, 5'd2, 5'd2, 5'd3}));
        chk("tick5_nowrap", 64'(o_wrap), 64'd0);
        repeat (5) tick();
        chk("tick10", 64'(o_codes), 64'({5'd3, BL, BL, BL, BL, BL}));
        tick();
        chk("tick11_codes", 64'(o_codes), 64'(ALL_BLANK));
        chk("tick11_wrap", 64'(o_wrap), 64'd1);
        cyc();
        chk("wrap_one_cycle", 64'(o_wrap), 64'd0);

        // Reverse direction from p = 0
        stop(); start(5);
        i_dir = 1'b1;
        tick();
        chk("rev_codes", 64'(o_codes), 64'({5'd3, BL, BL, BL, BL, BL}));
        chk("rev_wrap", 64'(o_wrap), 64'd1);
        i_dir = 1'b0;

        // Pause and stop
        stop(); start(5);
        repeat (3) tick();
        chk("p3_codes", 64'(o_codes), 64'({BL, BL, BL, 5'd0, 5'd1, 5'd2}));
        i_pause = 1'b1;
        cyc();
        repeat (4) tick();
        chk("pause_codes", 64'(o_codes), 64'({BL, BL, BL, 5'd0, 5'd1, 5'd2}));
        chk("pause_running", 64'(o_running), 64'd1);
        i_pause = 1'b0;
        cyc();
        tick();
        chk("p4_codes", 64'(o_codes), 64'({BL, BL, 5'd0, 5'd1, 5'd2, 5'd2}));
        i_stop = 1'b1; i_start = 1'b1; cyc(); i_stop = 1'b0; i_start = 1'b0;
        chk("stopstart_codes", 64'(o_codes), 64'(ALL_BLANK));
        chk("stopstart_running", 64'(o_running), 64'd0);

        // Illegal and boundary lengths
        start(0);
        chk("len0_running", 64'(o_running), 64'd0);
        start(17);
        chk("len17_running", 64'(o_running), 64'd0);
        start(16);
        chk("len16_running", 64'(o_running), 64'd1);
        stop();

        // Write lockout; tick on the start cycle is ignored
        start(5);
        wr(0, 5'd7);
        stop();
        i_tick = 1'b1; start(5); i_tick = 1'b0;
        chk("start_tick_ignored", 64'(o_codes), 64'(ALL_BLANK));
        tick();
        chk("lockout_digit5", 64'(o_codes), 64'({BL, BL, BL, BL, BL, 5'd0}));

        // Mid-run reset keeps the buffer
        tick();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst_codes", 64'(o_codes), 64'(ALL_BLANK));
        chk("midrst_running", 64'(o_running), 64'd0);
        start(5);
        tick();
        chk("buf_kept", 64'(o_codes), 64'({BL, BL, BL, BL, BL, 5'd0}));
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
